// File: rtl/apb_square_master.sv
// apb_square_master
//   For each accepted client request, runs three APB transfers against the
//   rectangle-area peripheral: write side a, write side b, read the area.
//   Returns the area, or an error flag if a transfer times out.
//
// Parameters
//   A_ADDR, B_ADDR, AREA_ADDR : 4-bit register addresses, zero-extended onto PADDR
//   TIMEOUT                   : ACCESS cycles allowed per transfer (2..255)
// Ports
//   PCLK, PRESETn                       : clock, async active-low reset
//   req_valid/req_ready/req_a/req_b     : request handshake and operands
//   rsp_valid/rsp_ready/rsp_area/rsp_error : response handshake and result
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY : APB master port
module apb_square_master #(
  parameter logic [3:0]  A_ADDR    = 4'h0,
  parameter logic [3:0]  B_ADDR    = 4'h4,
  parameter logic [3:0]  AREA_ADDR = 4'h8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_area,
  output logic        rsp_error,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e      r_state,     w_state_nxt;
  logic [31:0] r_a,         w_a_nxt;
  logic [31:0] r_b,         w_b_nxt;
  logic [1:0]  r_idx,       w_idx_nxt;
  logic [7:0]  r_cnt,       w_cnt_nxt;
  logic        r_req_ready, w_req_ready_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_area,  w_rsp_area_nxt;
  logic        r_rsp_error, w_rsp_error_nxt;
  logic        r_psel,      w_psel_nxt;
  logic        r_penable,   w_penable_nxt;
  logic        r_pwrite,    w_pwrite_nxt;
  logic [31:0] r_paddr,     w_paddr_nxt;
  logic [31:0] r_pwdata,    w_pwdata_nxt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_area  <= '0;
      r_rsp_error <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_area  <= w_rsp_area_nxt;
      r_rsp_error <= w_rsp_error_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_area_nxt  = r_rsp_area;
    w_rsp_error_nxt = r_rsp_error;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;

    unique case (r_state)
      StIdle: begin
        // req_ready first rises on the edge after reset release
        w_req_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_state_nxt     = StSetup;
          w_a_nxt         = req_a;
          w_b_nxt         = req_b;
          w_idx_nxt       = 2'd0;
          w_req_ready_nxt = 1'b0;
          w_psel_nxt      = 1'b1;
          w_penable_nxt   = 1'b0;
          w_pwrite_nxt    = 1'b1;
          w_paddr_nxt     = 32'(A_ADDR);
          w_pwdata_nxt    = req_a;
        end
      end
      StSetup: begin
        w_state_nxt   = StAccess;
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
      end
      StAccess: begin
        if (PREADY) begin
          w_penable_nxt = 1'b0;
          if (r_idx == 2'd2) begin
            w_state_nxt     = StResp;
            w_psel_nxt      = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_area_nxt  = PRDATA;
            w_rsp_error_nxt = 1'b0;
          end else begin
            w_state_nxt = StSetup;
            w_idx_nxt   = r_idx + 2'd1;
            if (r_idx == 2'd0) begin
              w_pwrite_nxt = 1'b1;
              w_paddr_nxt  = 32'(B_ADDR);
              w_pwdata_nxt = r_b;
            end else begin
              w_pwrite_nxt = 1'b0;
              w_paddr_nxt  = 32'(AREA_ADDR);
              w_pwdata_nxt = '0;
            end
          end
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          // Abort: skip the remaining transfers and report the error
          w_state_nxt     = StResp;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_area_nxt  = '0;
          w_rsp_error_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_nxt     = StIdle;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_area  = r_rsp_area;
  assign rsp_error = r_rsp_error;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_square_master.sv
module tb_apb_square_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
  logic [31:0] req_a, req_b, rsp_area;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_square_master dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_area  (rsp_area),
    .rsp_error (rsp_error),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Area peripheral: one-cycle PREADY after seeing PSEL && PENABLE
  bit          slave_ok;
  logic [31:0] sa, sb;
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY <= 1'b0;
      sa     <= '0;
      sb     <= '0;
    end else begin
      PREADY <= PSEL && PENABLE && !PREADY && slave_ok;
      if (PSEL && PENABLE && PREADY && PWRITE) begin
        if (PADDR == 32'h0) sa <= PWDATA;
        if (PADDR == 32'h4) sb <= PWDATA;
      end
    end
  end
  assign PRDATA = (PADDR == 32'h8) ? sa * sb : 32'h0;

  // Completed-transfer log and protocol checks
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;
  xfer_t       log_q[$];
  logic        s_wr;
  logic [31:0] s_addr, s_data;

  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PENABLE) begin
        check("penable_needs_psel", 32'(PSEL), 32'd1);
        check("paddr_stable", PADDR, s_addr);
        check("pwrite_stable", 32'(PWRITE), 32'(s_wr));
        check("pwdata_stable", PWDATA, s_data);
        if (PREADY) log_q.push_back('{PWRITE, PADDR, PWRITE ? PWDATA : PRDATA});
      end else if (PSEL) begin
        s_wr   = PWRITE;
        s_addr = PADDR;
        s_data = PWDATA;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, PSEL, PENABLE, PWRITE, req_ready, rsp_valid, rsp_error}, 32'd0);
    check({tag, "_paddr"}, PADDR, 32'd0);
    check({tag, "_pwdata"}, PWDATA, 32'd0);
    check({tag, "_area"}, rsp_area, 32'd0);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input bit stuck,
                        input int bp);
    int    n;
    xfer_t exp_x [3];
    logic [31:0] exp_area;
    exp_area = stuck ? 32'd0 : a * b;
    exp_x[0] = '{1'b1, 32'h0, a};
    exp_x[1] = '{1'b1, 32'h4, b};
    exp_x[2] = '{1'b0, 32'h8, a * b};
    slave_ok = !stuck;
    log_q.delete();
    n = 0;
    while (!req_ready && n < 50) begin @(posedge PCLK); #1; n++; end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    check("req_ready_drop", 32'(req_ready), 32'd0);
    check("setup_a", {29'd0, PSEL, PENABLE, PWRITE}, 32'b101);
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge PCLK); #1; n++; end
    check("latency", n, stuck ? 32'd17 : 32'd9);
    check("rsp_area", rsp_area, exp_area);
    check("rsp_error", 32'(rsp_error), 32'(stuck));
    check("psel_in_resp", 32'(PSEL), 32'd0);
    check("xfer_count", log_q.size(), stuck ? 32'd0 : 32'd3);
    if (log_q.size() == 3 && !stuck) begin
      for (int i = 0; i < 3; i++) begin
        check("xfer_wr", 32'(log_q[i].wr), 32'(exp_x[i].wr));
        check("xfer_addr", log_q[i].addr, exp_x[i].addr);
        check("xfer_data", log_q[i].data, exp_x[i].data);
      end
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge PCLK); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_area", rsp_area, exp_area);
      check("bp_error", 32'(rsp_error), 32'(stuck));
      check("bp_busy", {30'd0, req_ready, PSEL}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
    check("area_hold", rsp_area, exp_area);
    check("error_hold", 32'(rsp_error), 32'(stuck));
  endtask

  initial begin
    int n;
    PRESETn   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    slave_ok  = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 check_all_zero("reset");
    @(negedge PCLK) PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("req_ready_after_reset", 32'(req_ready), 32'd1);

    do_req(32'd3, 32'd5, 1'b0, 0);
    do_req(32'h0001_0000, 32'h0001_0000, 1'b0, 0);
    do_req(32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    do_req($urandom, $urandom, 1'b0, 5);
    do_req(32'd7, 32'd6, 1'b0, 0);
    do_req($urandom, $urandom, 1'b1, 2);
    do_req($urandom, $urandom, 1'b0, 0);

    // Reset during ACCESS of the side-b write
    slave_ok  = 1'b1;
    req_valid = 1'b1;
    req_a     = 32'd11;
    req_b     = 32'd13;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    n = 0;
    while (!(PENABLE && PADDR == 32'h4) && n < 20) begin @(posedge PCLK); #1; n++; end
    check("reach_b_access", {31'd0, PENABLE}, 32'd1);
    #2 PRESETn = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(posedge PCLK);
    #1 check_all_zero("mid_reset_held");
    @(negedge PCLK) PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("req_ready_after_abort", 32'(req_ready), 32'd1);
    check("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
    do_req(32'd2, 32'd9, 1'b0, 0);

    for (int i = 0; i < 8; i++) do_req($urandom, $urandom, 1'b0, int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
